// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage access unit.
//   state_t             FSM encoding (IDLE=0, WAIT=1)
//   ALIGN_MASK          low address bits that must be zero for a word access
//   TIMEOUT_CYCLES_DEF  default WAIT budget when MEM_TIMEOUT_EN is defined
package mem_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   localparam logic [1:0] ALIGN_MASK         = 2'b11;
   localparam int         TIMEOUT_CYCLES_DEF = 255;

   function automatic logic is_aligned(input logic [31:0] addr);
      return (addr[1:0] & ALIGN_MASK) == 2'b00;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory request/response bundle.
//   dm_req, dm_we, dm_addr, dm_wdata  unit -> memory
//   dm_ack, dm_rdata                  memory -> unit
//   modport master: the access unit; modport slave: the memory.
interface mem_access_unit_if;

   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;

   modport master (
      output dm_req, dm_we, dm_addr, dm_wdata,
      input  dm_ack, dm_rdata
   );

   modport slave (
      input  dm_req, dm_we, dm_addr, dm_wdata,
      output dm_ack, dm_rdata
   );

endinterface

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register.
//   clk, rst      clock, async active-low reset (all outputs clear)
//   stall_i       1: insert bubble (regwrite cleared, other fields hold)
//   rdata_ld_i    1: capture rdata_i (completion of a memory access)
//   *_i / *_o     MEM/WB fields in / out
module mem_wb_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        rdata_ld_i,
   input  logic        regwrite_i,
   input  logic        memtoreg_i,
   input  logic [31:0] alu_out_i,
   input  logic [4:0]  mux_i,
   input  logic [31:0] rdata_i,
   output logic        regwrite_o,
   output logic        memtoreg_o,
   output logic [31:0] alu_out_o,
   output logic [4:0]  mux_o,
   output logic [31:0] rdata_o
);

   logic        regwrite_q;
   logic        memtoreg_q;
   logic [31:0] alu_out_q;
   logic [4:0]  mux_q;
   logic [31:0] rdata_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         alu_out_q  <= '0;
         mux_q      <= '0;
         rdata_q    <= '0;
      end else if (stall_i) begin
         regwrite_q <= 1'b0;
      end else begin
         regwrite_q <= regwrite_i;
         memtoreg_q <= memtoreg_i;
         alu_out_q  <= alu_out_i;
         mux_q      <= mux_i;
         if (rdata_ld_i) rdata_q <= rdata_i;
      end
   end

   assign regwrite_o = regwrite_q;
   assign memtoreg_o = memtoreg_q;
   assign alu_out_o  = alu_out_q;
   assign mux_o      = mux_q;
   assign rdata_o    = rdata_q;

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage controller. Issues one data-memory access per
// aligned load/store, stalls the front of the pipeline until dm_ack, and
// produces the branch/jump redirect.
//   clk, rst                    clock, async active-low reset
//   in_*                        EX/MEM control, flags, address/data, targets
//   dm                          data-memory bundle (master side)
//   stall                       hold PC, IF/ID, ID/EX, EX/MEM
//   pc_src, pc_target           redirect request and target
//   out_*                       MEM/WB fields
//   misalign_err, timeout_err   sticky error flags
// Build option: MEM_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYCLES cycles.
//
// state | meaning
// IDLE  | no access outstanding; aligned mem op launches a request
// WAIT  | dm_req high, waiting for dm_ack (or watchdog expiry)
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_RegWrite,
   input  logic              in_memoryToreg,
   input  logic              in_memoryRead,
   input  logic              in_memoryWrite,
   input  logic              in_Branch,
   input  logic              in_Jump,
   input  logic              in_zero,
   input  logic [31:0]       in_alu_out,
   input  logic [31:0]       in_rd2,
   input  logic [31:0]       in_pc_bgt,
   input  logic [31:0]       in_jump_addr,
   input  logic [4:0]        in_mux,
   mem_access_unit_if.master dm,
   output logic              stall,
   output logic              pc_src,
   output logic [31:0]       pc_target,
   output logic              out_RegWrite,
   output logic              out_memoryToreg,
   output logic [31:0]       out_rdata,
   output logic [31:0]       out_alu_out,
   output logic [4:0]        out_mux,
   output logic              misalign_err,
   output logic              timeout_err
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_t      state_q;
   logic        dm_req_q;
   logic        dm_we_q;
   logic [31:0] dm_addr_q;
   logic [31:0] dm_wdata_q;
   logic        misalign_q;

   logic mem_op, aligned, in_wait, go, ack_hit, tmo_hit, mis_hit, regwrite_mw;

   assign mem_op  = in_memoryRead | in_memoryWrite;
   assign aligned = is_aligned(in_alu_out);
   assign in_wait = (state_q == WAIT);
   assign go      = ~in_wait & mem_op & aligned;
   assign mis_hit = ~in_wait & mem_op & ~aligned;
   assign ack_hit = in_wait & dm.dm_ack;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] cnt_q;
   logic             timeout_q;
   // Down-counter loaded on entry to WAIT; terminal count is the last WAIT cycle.
   assign tmo_hit     = in_wait & ~dm.dm_ack & (cnt_q == '0);
   assign timeout_err = timeout_q;
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // A watchdog expiry releases the stall in the same cycle so the held
   // instruction retires (as a bubble) on the following edge.
   assign stall  = go | (in_wait & ~dm.dm_ack & ~tmo_hit);
   assign pc_src = ~stall & (in_Jump | (in_Branch & in_zero));
   assign pc_target = in_Jump ? in_jump_addr : in_pc_bgt;

   // No register write for read+write combos, misaligned ops or aborted accesses.
   assign regwrite_mw = in_RegWrite & ~(in_memoryRead & in_memoryWrite)
                      & ~(mem_op & ~aligned) & ~tmo_hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         dm_req_q   <= 1'b0;
         dm_we_q    <= 1'b0;
         dm_addr_q  <= '0;
         dm_wdata_q <= '0;
         misalign_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
`endif
      end else if (state_q == IDLE) begin
         if (go) begin
            state_q    <= WAIT;
            dm_req_q   <= 1'b1;
            dm_we_q    <= in_memoryWrite;
            dm_addr_q  <= in_alu_out;
            dm_wdata_q <= in_rd2;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= CNT_W'(TIMEOUT_CYCLES - 1);
`endif
         end
         if (mis_hit) misalign_q <= 1'b1;
      end else begin
         if (ack_hit || tmo_hit) begin
            state_q  <= IDLE;
            dm_req_q <= 1'b0;
            dm_we_q  <= 1'b0;
         end
`ifdef MEM_TIMEOUT_EN
         if (tmo_hit) timeout_q <= 1'b1;
         else         cnt_q     <= cnt_q - 1'b1;
`endif
      end
   end

   assign dm.dm_req     = dm_req_q;
   assign dm.dm_we      = dm_we_q;
   assign dm.dm_addr    = dm_addr_q;
   assign dm.dm_wdata   = dm_wdata_q;
   assign misalign_err  = misalign_q;

   mem_wb_reg u_mem_wb (
      .clk        (clk),
      .rst        (rst),
      .stall_i    (stall),
      .rdata_ld_i (ack_hit),
      .regwrite_i (regwrite_mw),
      .memtoreg_i (in_memoryToreg),
      .alu_out_i  (in_alu_out),
      .mux_i      (in_mux),
      .rdata_i    (dm.dm_rdata),
      .regwrite_o (out_RegWrite),
      .memtoreg_o (out_memoryToreg),
      .alu_out_o  (out_alu_out),
      .mux_o      (out_mux),
      .rdata_o    (out_rdata)
   );

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max WAIT cycles before abort (only with MEM_TIMEOUT_EN).
REQ-002 clk  input  1  single clock, all state on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in_RegWrite, in_memoryToreg, in_memoryRead, in_memoryWrite, in_Branch, in_Jump, in_zero  input  1 each  EX/MEM control and flag fields.
REQ-005 in_alu_out, in_rd2, in_pc_bgt, in_jump_addr  input  32 each  address/store data, branch target, jump target.
REQ-006 in_mux  input  5  destination register.
REQ-007 dm_req, dm_we  output  1 each  data-memory request and write-enable.
REQ-008 dm_addr, dm_wdata  output  32 each  latched address and store data.
REQ-009 dm_ack  input  1; dm_rdata  input  32  memory completion and load data.
REQ-010 stall  output  1  holds PC, IF/ID, ID/EX, EX/MEM.
REQ-011 pc_src  output  1; pc_target  output  32  redirect request and target.
REQ-012 out_RegWrite, out_memoryToreg  output  1 each; out_rdata, out_alu_out  output  32 each; out_mux  output  5  MEM/WB fields.
REQ-013 misalign_err, timeout_err  output  1 each  sticky error flags.

Function
REQ-014 FSM states SHALL be IDLE and WAIT only.
REQ-015 mem_op = in_memoryRead | in_memoryWrite; in IDLE with mem_op and in_alu_out[1:0]==0, unit SHALL latch dm_addr=in_alu_out, dm_wdata=in_rd2, dm_we=in_memoryWrite, go WAIT.
REQ-016 dm_req SHALL be 1 exactly while in WAIT (registered, no combinational path from inputs).
REQ-017 stall SHALL equal (IDLE & aligned mem_op) | (WAIT & !dm_ack), combinational.
REQ-018 WAIT with dm_ack SHALL return to IDLE next edge; dm_rdata SHALL be captured into out_rdata on that edge; minimum access latency 2 cycles.
REQ-019 dm_ack in IDLE SHALL be ignored.
REQ-020 Read and write both asserted: SHALL perform write only, out_RegWrite forced 0.
REQ-021 Misaligned mem_op (in_alu_out[1:0]!=0): no request, no stall, out_RegWrite forced 0, misalign_err set.
REQ-022 MEM/WB fields SHALL load on posedge only when stall==0; when stall==1 out_RegWrite SHALL load 0 (bubble), other fields hold.
REQ-023 pc_src = !stall & (in_Jump | (in_Branch & in_zero)); pc_target = in_Jump ? in_jump_addr : in_pc_bgt (Jump priority).
REQ-024 Non-memory instruction SHALL pass through in one cycle, out_rdata holding.

Reset
REQ-025 rst low SHALL immediately force IDLE, dm_req=0, dm_we=0, dm_addr=dm_wdata=0, all MEM/WB outputs 0, both error flags 0, including mid-WAIT.
REQ-026 After rst release, first action SHALL occur on the first posedge with rst high.

Configuration
REQ-027 Macro MEM_TIMEOUT_EN defined: 8-bit-or-wider WAIT counter; at TIMEOUT_CYCLES without dm_ack, dm_req drops, state IDLE, stall released that cycle, out_RegWrite forced 0, timeout_err set.
REQ-028 Macro undefined: WAIT persists until dm_ack, timeout_err tied 0, no counter logic.

Structure
REQ-029 Shared package mem_pkg SHALL hold the state encoding (IDLE=0, WAIT=1), the alignment mask 2'b11 and the TIMEOUT_CYCLES default.
REQ-030 MEM/WB register SHALL be sub-module mem_wb_reg (clk, rst, stall-gated load, bubble insert); FSM and branch logic stay in top.

Verification
REQ-031 Load, in_alu_out=0x10, dm_ack 3 cycles after dm_req -> stall high 4 cycles, dm_addr=0x10, out_rdata=dm_rdata, out_RegWrite=1 one cycle after ack.
REQ-032 Store, in_alu_out=0x20, in_rd2=0xDEADBEEF, ack immediate -> dm_we=1, dm_wdata=0xDEADBEEF, stall exactly 1 cycle, out_RegWrite=0.
REQ-033 Load with in_alu_out=0x13 -> dm_req stays 0, stall 0, misalign_err=1 sticky until rst.
REQ-034 in_Branch=1, in_zero=1, in_pc_bgt=0x40, in_Jump=1, in_jump_addr=0x80 -> pc_src=1, pc_target=0x80; during stall pc_src=0.
REQ-035 rst low in WAIT -> dm_req=0 before next posedge; with MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> req drops after 4 WAIT cycles, timeout_err=1.
